bus_xbar: RTL

Parametrised single-master, N-slave request router for the SoC native valid/ready bus, replacing the fixed three-way natv/mmap/psram split between `core_wrapper` and the peripheral wrappers. It decodes the core address against a base/mask table and registers the selected slave. It forwards one transaction at a time and returns read data to the core. Unmapped accesses and (optionally) hung slaves are terminated with an error response, so the core never stalls forever.

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_addr_dec.sv | 28 ++
 rtl/bus_xbar.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_xbar shared definitions: FSM states, error data default, slave limit.
// Imported by the router top and its address decoder.
package bus_pkg;

   localparam int          BUS_MAX_SLV   = 16;
   localparam logic [31:0] BUS_ERR_RDATA = 32'hBADC_0DE5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } bus_state_e;

endpackage

// File: rtl/bus_addr_dec.sv
// Priority address decoder: hit when (addr & mask) == base.
// The lowest-index matching slave wins.
module bus_addr_dec #(
   parameter int                              NUM_SLV    = 4,
   parameter int                              ADDR_WIDTH = 32,
   parameter int                              IDX_W      = 2,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_BASE   = '0,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_MASK   = '0
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  o_hit,
   output logic [IDX_W-1:0]      o_idx
);

   // Scan from the top so the lowest matching index is the last to assign
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((i_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bus_xbar.sv
// Single-master, N-slave valid/ready request router with error termination.
// Optional slave timeout is built when BUS_TIMEOUT_EN is defined.
module bus_xbar
   import bus_pkg::*;
#(
   parameter int                              NUM_SLV        = 4,
   parameter int                              ADDR_WIDTH     = 32,
   parameter int                              DATA_WIDTH     = 32,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_BASE       = '0,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_MASK       = '0,
   parameter int                              TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0]           ERR_RDATA      = DATA_WIDTH'(BUS_ERR_RDATA)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            core_valid_i,
   input  logic [ADDR_WIDTH-1:0]           core_addr_i,
   input  logic [DATA_WIDTH-1:0]           core_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]         core_wstrb_i,
   output logic [DATA_WIDTH-1:0]           core_rdata_o,
   output logic                            core_ready_o,
   output logic [NUM_SLV-1:0]              slv_valid_o,
   output logic [ADDR_WIDTH-1:0]           slv_addr_o,
   output logic [DATA_WIDTH-1:0]           slv_wdata_o,
   output logic [DATA_WIDTH/8-1:0]         slv_wstrb_o,
   input  logic [NUM_SLV*DATA_WIDTH-1:0]   slv_rdata_i,
   input  logic [NUM_SLV-1:0]              slv_ready_i,
   output logic                            err_o,
   output logic [ADDR_WIDTH-1:0]           err_addr_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   if (NUM_SLV < 1 || NUM_SLV > BUS_MAX_SLV || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("bus_xbar: unsupported NUM_SLV or TIMEOUT_CYCLES");
   end

   bus_state_e              r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [NUM_SLV-1:0]      r_slv_valid;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]       r_wstrb;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_ready;
   logic                    r_err;
   logic [ADDR_WIDTH-1:0]   r_err_addr;

   logic                    w_hit;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_sel_rdy;
   logic [DATA_WIDTH-1:0]   w_sel_rdata;
   logic                    w_expire;

   bus_addr_dec #(
      .NUM_SLV    (NUM_SLV),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IDX_W      (IDX_W),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_dec (
      .i_addr (core_addr_i),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   // Pick ready and read data of the latched slave only
   always_comb begin
      w_sel_rdy   = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_sel_rdy   = slv_ready_i[i];
            w_sel_rdata = slv_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;

   // Count cycles spent waiting in ACTIVE; zero whenever not active
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (r_state != ST_ACTIVE) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Expiry in the cycle where the waited count reaches the limit
   assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_expire = 1'b0;
`endif

   // Request FSM: decode, forward to one slave, respond for one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_slv_valid <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rdata     <= '0;
         r_ready     <= 1'b0;
         r_err       <= 1'b0;
         r_err_addr  <= '0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (core_valid_i) begin
                  r_addr  <= core_addr_i;
                  r_wdata <= core_wdata_i;
                  r_wstrb <= core_wstrb_i;
                  r_idx   <= w_idx;
                  if (w_hit) begin
                     r_slv_valid <= NUM_SLV'(1) << w_idx;
                     r_state     <= ST_ACTIVE;
                  end else begin
                     r_rdata    <= ERR_RDATA;
                     r_err_addr <= core_addr_i;
                     r_ready    <= 1'b1;
                     r_err      <= 1'b1;
                     r_state    <= ST_RESP;
                  end
               end
            end
            ST_ACTIVE: begin
               if (w_sel_rdy) begin
                  r_rdata     <= w_sel_rdata;
                  r_slv_valid <= '0;
                  r_ready     <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (w_expire) begin
                  r_rdata     <= ERR_RDATA;
                  r_err_addr  <= r_addr;
                  r_slv_valid <= '0;
                  r_ready     <= 1'b1;
                  r_err       <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign core_rdata_o = r_rdata;
   assign core_ready_o = r_ready;
   assign slv_valid_o  = r_slv_valid;
   assign slv_addr_o   = r_addr;
   assign slv_wdata_o  = r_wdata;
   assign slv_wstrb_o  = r_wstrb;
   assign err_o        = r_err;
   assign err_addr_o   = r_err_addr;

endmodule
